// File: rtl/sat_core_pkg.sv
// Shared types and result codes for the SAT core sequencer.
package sat_core_pkg;

    localparam int RES_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BCP,
        ST_DECISION,
        ST_ANALYSIS,
        ST_BKT_CUR_BIN,
        ST_REPORT
    } state_e;

    localparam logic [RES_W-1:0] RES_NONE   = 3'd0;
    localparam logic [RES_W-1:0] RES_SAT    = 3'd1;
    localparam logic [RES_W-1:0] RES_UNSAT  = 3'd2;
    localparam logic [RES_W-1:0] RES_BUDGET = 3'd3;
    localparam logic [RES_W-1:0] RES_ABORT  = 3'd4;

endpackage

// File: rtl/sat_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_sat_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sat_core_ctrl.sv
// Bin-solve sequencer: drives the BCP / decision / analysis / backtrack loop and
// reports SAT, UNSAT, BUDGET or ABORT with per-solve statistics.
module sat_core_ctrl
    import sat_core_pkg::*;
#(
    parameter int WIDTH_BIN_ID = 10,
    parameter int WIDTH_LVL    = 16,
    parameter int WIDTH_CNT    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_core_i,
    input  logic                    abort_i,
    input  logic [WIDTH_CNT-1:0]    max_conflicts_i,
    output logic                    done_core_o,
    output logic [RES_W-1:0]        result_o,
    output logic                    sat_o,
    output logic                    unsat_o,
    output logic                    busy_o,
    output logic                    apply_imply_o,
    input  logic                    done_imply_i,
    input  logic                    conflict_i,
    output logic                    start_decision_o,
    input  logic                    done_decision_i,
    input  logic                    all_c_is_sat_i,
    input  logic [WIDTH_LVL-1:0]    cur_lvl_i,
    output logic                    apply_analyze_o,
    input  logic                    done_analyze_i,
    input  logic [WIDTH_BIN_ID-1:0] bkt_bin_num_i,
    input  logic [WIDTH_BIN_ID-1:0] cur_bin_num_i,
    output logic                    apply_bkt_cur_bin_o,
    input  logic                    done_bkt_cur_bin_i,
    output logic [WIDTH_CNT-1:0]    conflict_cnt_o,
    output logic [WIDTH_CNT-1:0]    decision_cnt_o,
    output logic [WIDTH_CNT-1:0]    cycle_cnt_o,
    output logic [WIDTH_LVL-1:0]    max_lvl_o
);

    localparam logic [WIDTH_CNT-1:0] CNT_ONE = {{(WIDTH_CNT-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_CNT-1:0] CNT_MAX = {WIDTH_CNT{1'b1}};

    state_e                 state_q, state_d;
    logic [RES_W-1:0]       result_q, result_d;
    logic [WIDTH_CNT-1:0]   budget_q, budget_d;
    logic [WIDTH_LVL-1:0]   max_lvl_q, max_lvl_d;
    logic                   sat_q, sat_d;
    logic                   unsat_q, unsat_d;
    logic                   busy_q, busy_d;
    logic                   done_core_q, done_core_d;
    logic                   apply_imply_q, apply_imply_d;
    logic                   start_decision_q, start_decision_d;
    logic                   apply_analyze_q, apply_analyze_d;
    logic                   apply_bkt_q, apply_bkt_d;

    logic                   start_acc;
    logic                   conflict_inc;
    logic                   decision_inc;
    logic                   cycle_inc;
    logic                   imply_vld;
    logic                   decision_vld;
    logic                   analyze_vld;
    logic                   bkt_vld;
    logic [WIDTH_CNT-1:0]   conflict_next;

    // A done arriving while its own start pulse is still high is a leftover from the previous round.
    assign imply_vld     = done_imply_i && !apply_imply_q;
    assign decision_vld  = done_decision_i && !start_decision_q;
    assign analyze_vld   = done_analyze_i && !apply_analyze_q;
    assign bkt_vld       = done_bkt_cur_bin_i && !apply_bkt_q;
    assign conflict_next = (conflict_cnt_o == CNT_MAX) ? CNT_MAX : conflict_cnt_o + CNT_ONE;
    assign cycle_inc     = (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        budget_d     = budget_q;
        max_lvl_d    = max_lvl_q;
        start_acc    = 1'b0;
        conflict_inc = 1'b0;
        decision_inc = 1'b0;
        if (abort_i && (state_q != ST_IDLE) && (state_q != ST_REPORT)) begin
            state_d  = ST_REPORT;
            result_d = RES_ABORT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_core_i) begin
                        state_d   = ST_BCP;
                        result_d  = RES_NONE;
                        budget_d  = max_conflicts_i;
                        max_lvl_d = '0;
                        start_acc = 1'b1;
                    end
                end
                ST_BCP: begin
                    if (imply_vld) begin
                        if (conflict_i) begin
                            conflict_inc = 1'b1;
                            if ((budget_q != '0) && (conflict_next >= budget_q)) begin
                                state_d  = ST_REPORT;
                                result_d = RES_BUDGET;
                            end else begin
                                state_d = ST_ANALYSIS;
                            end
                        end else if (all_c_is_sat_i) begin
                            state_d  = ST_REPORT;
                            result_d = RES_SAT;
                        end else begin
                            state_d = ST_DECISION;
                        end
                    end
                end
                ST_DECISION: begin
                    if (decision_vld) begin
                        decision_inc = 1'b1;
                        if (cur_lvl_i > max_lvl_q) begin
                            max_lvl_d = cur_lvl_i;
                        end
                        if (all_c_is_sat_i) begin
                            state_d  = ST_REPORT;
                            result_d = RES_SAT;
                        end else begin
                            state_d = ST_BCP;
                        end
                    end
                end
                ST_ANALYSIS: begin
                    if (analyze_vld) begin
                        if (bkt_bin_num_i != cur_bin_num_i) begin
                            state_d  = ST_REPORT;
                            result_d = RES_UNSAT;
                        end else begin
                            state_d = ST_BKT_CUR_BIN;
                        end
                    end
                end
                ST_BKT_CUR_BIN: begin
                    if (bkt_vld) begin
                        state_d = ST_BCP;
                    end
                end
                ST_REPORT: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered off the next state so every start pulse lands on the first residency cycle.
    always_comb begin
        sat_d            = (result_d == RES_SAT);
        unsat_d          = (result_d == RES_UNSAT);
        busy_d           = (state_d != ST_IDLE);
        done_core_d      = (state_d == ST_REPORT);
        apply_imply_d    = (state_d == ST_BCP) && (state_q != ST_BCP);
        start_decision_d = (state_d == ST_DECISION) && (state_q != ST_DECISION);
        apply_analyze_d  = (state_d == ST_ANALYSIS) && (state_q != ST_ANALYSIS);
        apply_bkt_d      = (state_d == ST_BKT_CUR_BIN) && (state_q != ST_BKT_CUR_BIN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            result_q         <= RES_NONE;
            budget_q         <= '0;
            max_lvl_q        <= '0;
            sat_q            <= 1'b0;
            unsat_q          <= 1'b0;
            busy_q           <= 1'b0;
            done_core_q      <= 1'b0;
            apply_imply_q    <= 1'b0;
            start_decision_q <= 1'b0;
            apply_analyze_q  <= 1'b0;
            apply_bkt_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            result_q         <= result_d;
            budget_q         <= budget_d;
            max_lvl_q        <= max_lvl_d;
            sat_q            <= sat_d;
            unsat_q          <= unsat_d;
            busy_q           <= busy_d;
            done_core_q      <= done_core_d;
            apply_imply_q    <= apply_imply_d;
            start_decision_q <= start_decision_d;
            apply_analyze_q  <= apply_analyze_d;
            apply_bkt_q      <= apply_bkt_d;
        end
    end

    sat_sat_cnt #(.WIDTH(WIDTH_CNT)) u_conflict_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .inc   (conflict_inc),
        .cnt_o (conflict_cnt_o)
    );

    sat_sat_cnt #(.WIDTH(WIDTH_CNT)) u_decision_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .inc   (decision_inc),
        .cnt_o (decision_cnt_o)
    );

    sat_sat_cnt #(.WIDTH(WIDTH_CNT)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .inc   (cycle_inc),
        .cnt_o (cycle_cnt_o)
    );

    assign done_core_o         = done_core_q;
    assign result_o            = result_q;
    assign sat_o               = sat_q;
    assign unsat_o             = unsat_q;
    assign busy_o              = busy_q;
    assign apply_imply_o       = apply_imply_q;
    assign start_decision_o    = start_decision_q;
    assign apply_analyze_o     = apply_analyze_q;
    assign apply_bkt_cur_bin_o = apply_bkt_q;
    assign max_lvl_o           = max_lvl_q;

endmodule

// File: tb/tb_sat_core_ctrl.sv
// Randomized bench for sat_core_ctrl; a second instance with 4-bit counters exercises saturation.
module tb_sat_core_ctrl;
    import sat_core_pkg::*;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_IMP  = 5'b10000;
    localparam logic [4:0] P_DEC  = 5'b01000;
    localparam logic [4:0] P_ANA  = 5'b00100;
    localparam logic [4:0] P_BKT  = 5'b00010;
    localparam logic [4:0] P_DONE = 5'b00001;

    localparam int M_RANDOM = 0;
    localparam int M_SAT    = 1;
    localparam int M_UNSAT  = 2;
    localparam int M_CONF   = 3;
    localparam int M_ABORT  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_core, abort_in;
    logic [31:0] max_conflicts;
    logic        done_imply, conflict, done_decision, all_sat, done_analyze, done_bkt;
    logic [15:0] cur_lvl;
    logic [9:0]  bkt_bin, cur_bin;

    logic        done_core, sat, unsat, busy;
    logic        apply_imply, start_decision, apply_analyze, apply_bkt;
    logic [2:0]  result;
    logic [31:0] conflict_cnt, decision_cnt, cycle_cnt;
    logic [15:0] max_lvl;

    logic [3:0]  s_max;
    logic        s_done_core, s_sat, s_unsat, s_busy;
    logic        s_apply_imply, s_start_decision, s_apply_analyze, s_apply_bkt;
    logic [2:0]  s_result;
    logic [3:0]  s_conflict_cnt, s_decision_cnt, s_cycle_cnt;
    logic [15:0] s_max_lvl;

    int check_count = 0;
    int pass_count  = 0;
    int busy_cycles = 0;

    always #5 clk = ~clk;

    sat_core_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_core_i        (start_core),
        .abort_i             (abort_in),
        .max_conflicts_i     (max_conflicts),
        .done_core_o         (done_core),
        .result_o            (result),
        .sat_o               (sat),
        .unsat_o             (unsat),
        .busy_o              (busy),
        .apply_imply_o       (apply_imply),
        .done_imply_i        (done_imply),
        .conflict_i          (conflict),
        .start_decision_o    (start_decision),
        .done_decision_i     (done_decision),
        .all_c_is_sat_i      (all_sat),
        .cur_lvl_i           (cur_lvl),
        .apply_analyze_o     (apply_analyze),
        .done_analyze_i      (done_analyze),
        .bkt_bin_num_i       (bkt_bin),
        .cur_bin_num_i       (cur_bin),
        .apply_bkt_cur_bin_o (apply_bkt),
        .done_bkt_cur_bin_i  (done_bkt),
        .conflict_cnt_o      (conflict_cnt),
        .decision_cnt_o      (decision_cnt),
        .cycle_cnt_o         (cycle_cnt),
        .max_lvl_o           (max_lvl)
    );

    sat_core_ctrl #(.WIDTH_CNT(4)) dut_small (
        .clk                 (clk),
        .rst                 (rst),
        .start_core_i        (start_core),
        .abort_i             (abort_in),
        .max_conflicts_i     (s_max),
        .done_core_o         (s_done_core),
        .result_o            (s_result),
        .sat_o               (s_sat),
        .unsat_o             (s_unsat),
        .busy_o              (s_busy),
        .apply_imply_o       (s_apply_imply),
        .done_imply_i        (done_imply),
        .conflict_i          (conflict),
        .start_decision_o    (s_start_decision),
        .done_decision_i     (done_decision),
        .all_c_is_sat_i      (all_sat),
        .cur_lvl_i           (cur_lvl),
        .apply_analyze_o     (s_apply_analyze),
        .done_analyze_i      (done_analyze),
        .bkt_bin_num_i       (bkt_bin),
        .cur_bin_num_i       (cur_bin),
        .apply_bkt_cur_bin_o (s_apply_bkt),
        .done_bkt_cur_bin_i  (done_bkt),
        .conflict_cnt_o      (s_conflict_cnt),
        .decision_cnt_o      (s_decision_cnt),
        .cycle_cnt_o         (s_cycle_cnt),
        .max_lvl_o           (s_max_lvl)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: sample at the falling edge, then drop all single-cycle inputs.
    task automatic advance(input logic [4:0] exp_vec, input logic exp_busy);
        @(negedge clk);
        checkOutput("pulses", {59'd0, apply_imply, start_decision, apply_analyze, apply_bkt, done_core},
                    {59'd0, exp_vec});
        checkOutput("busy", {63'd0, busy}, {63'd0, exp_busy});
        if (exp_busy) busy_cycles++;
        start_core    = 1'b0;
        abort_in      = 1'b0;
        done_imply    = 1'b0;
        done_decision = 1'b0;
        done_analyze  = 1'b0;
        done_bkt      = 1'b0;
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_result"}, {61'd0, result}, {61'd0, RES_NONE});
        checkOutput({tag, "_flags"}, {61'd0, sat, unsat, done_core}, 64'd0);
        checkOutput({tag, "_conflict_cnt"}, {32'd0, conflict_cnt}, 64'd0);
        checkOutput({tag, "_decision_cnt"}, {32'd0, decision_cnt}, 64'd0);
        checkOutput({tag, "_cycle_cnt"}, {32'd0, cycle_cnt}, 64'd0);
        checkOutput({tag, "_max_lvl"}, {48'd0, max_lvl}, 64'd0);
    endtask

    // Plays the four units for one solve and scores it against the solve rules.
    task automatic applyStimulus(input int mode, input logic [31:0] max_c, input int n_conf, input bit chk_small);
        int          phase, bcp_idx, ana_idx, steps, d, abort_at;
        int          exp_conf, exp_dec;
        logic [2:0]  exp_res;
        logic [15:0] exp_lvl, o_lvl;
        logic [9:0]  o_cur, o_bkt;
        bit          stale, finished, o_conf, o_sat, o_leave;
        logic [4:0]  nxt;
        phase = 0; bcp_idx = 0; ana_idx = 0; steps = 0;
        exp_conf = 0; exp_dec = 0; exp_res = RES_NONE; exp_lvl = 16'd0; finished = 0;
        busy_cycles = 0;
        max_conflicts = max_c;
        start_core = 1'b1;
        advance(P_IMP, 1'b1);
        checkOutput("result_cleared", {61'd0, result}, {61'd0, RES_NONE});
        if (mode == M_RANDOM) max_conflicts = $urandom;
        while (!finished) begin
            d = $urandom_range(0, 2);
            stale = (d == 0) && ($urandom_range(0, 1) == 1);
            abort_at = -1;
            if (mode == M_RANDOM && $urandom_range(0, 99) < 6) abort_at = $urandom_range(0, d + 1);
            if (mode == M_ABORT && phase == 1) abort_at = d + 1;
            o_conf = 0; o_sat = 0; o_leave = 0;
            o_lvl = 16'($urandom_range(0, 300));
            o_cur = 10'($urandom);
            o_bkt = o_cur;
            case (phase)
                0: begin
                    if (mode == M_RANDOM) begin
                        o_conf = (steps < 30) && ($urandom_range(0, 99) < 50);
                        o_sat  = (steps >= 30) || ($urandom_range(0, 99) < 15);
                    end else if (mode == M_SAT) begin
                        o_sat = (bcp_idx == 1);
                    end else if (mode == M_UNSAT) begin
                        o_conf = 1;
                    end else if (mode == M_CONF) begin
                        o_conf = (bcp_idx < n_conf);
                        o_sat  = !o_conf;
                    end
                    bcp_idx++;
                end
                1: begin
                    if (mode == M_RANDOM) o_sat = ($urandom_range(0, 99) < 15);
                    if (mode == M_SAT) o_lvl = 16'd1;
                    if (mode == M_ABORT) o_lvl = 16'd7;
                end
                2: begin
                    if (mode == M_RANDOM) o_leave = ($urandom_range(0, 99) < 15);
                    if (mode == M_UNSAT) begin
                        o_cur   = 10'd3;
                        o_leave = (ana_idx == 1);
                        o_bkt   = o_leave ? 10'd2 : 10'd3;
                    end else if (o_leave) begin
                        o_bkt = o_cur + 10'($urandom_range(1, 1023));
                    end
                    ana_idx++;
                end
                default: ;
            endcase
            steps++;
            for (int i = 0; i <= d + 1; i++) begin
                conflict = 1'($urandom);
                all_sat  = 1'($urandom);
                cur_lvl  = 16'($urandom);
                cur_bin  = 10'($urandom);
                bkt_bin  = 10'($urandom);
                if (mode == M_RANDOM) start_core = ($urandom_range(0, 3) == 0);
                if (i == d + 1 || (stale && i == 0)) begin
                    conflict = o_conf;
                    all_sat  = o_sat;
                    cur_lvl  = o_lvl;
                    cur_bin  = o_cur;
                    bkt_bin  = o_bkt;
                    case (phase)
                        0:       done_imply    = 1'b1;
                        1:       done_decision = 1'b1;
                        2:       done_analyze  = 1'b1;
                        default: done_bkt      = 1'b1;
                    endcase
                end
                if (i == abort_at) begin
                    abort_in = 1'b1;
                    exp_res  = RES_ABORT;
                    finished = 1;
                    advance(P_DONE, 1'b1);
                    break;
                end
                if (i < d + 1) begin
                    advance(P_NONE, 1'b1);
                end else begin
                    nxt = P_DONE;
                    case (phase)
                        0: begin
                            if (o_conf) begin
                                exp_conf++;
                                if (max_c != 0 && 32'(exp_conf) >= max_c) begin
                                    exp_res = RES_BUDGET; finished = 1;
                                end else begin
                                    phase = 2; nxt = P_ANA;
                                end
                            end else if (o_sat) begin
                                exp_res = RES_SAT; finished = 1;
                            end else begin
                                phase = 1; nxt = P_DEC;
                            end
                        end
                        1: begin
                            exp_dec++;
                            if (o_lvl > exp_lvl) exp_lvl = o_lvl;
                            if (o_sat) begin
                                exp_res = RES_SAT; finished = 1;
                            end else begin
                                phase = 0; nxt = P_IMP;
                            end
                        end
                        2: begin
                            if (o_leave) begin
                                exp_res = RES_UNSAT; finished = 1;
                            end else begin
                                phase = 3; nxt = P_BKT;
                            end
                        end
                        default: begin
                            phase = 0; nxt = P_IMP;
                        end
                    endcase
                    advance(nxt, 1'b1);
                end
            end
        end
        checkOutput("result", {61'd0, result}, {61'd0, exp_res});
        checkOutput("sat_flag", {63'd0, sat}, {63'd0, (exp_res == RES_SAT)});
        checkOutput("unsat_flag", {63'd0, unsat}, {63'd0, (exp_res == RES_UNSAT)});
        checkOutput("conflict_cnt", {32'd0, conflict_cnt}, 64'(exp_conf));
        checkOutput("decision_cnt", {32'd0, decision_cnt}, 64'(exp_dec));
        checkOutput("max_lvl", {48'd0, max_lvl}, {48'd0, exp_lvl});
        start_core = 1'b1;
        advance(P_NONE, 1'b0);
        checkOutput("cycle_cnt", {32'd0, cycle_cnt}, 64'(busy_cycles));
        if (chk_small) begin
            checkOutput("small_cycle_sat", {60'd0, s_cycle_cnt}, (busy_cycles > 15) ? 64'd15 : 64'(busy_cycles));
            checkOutput("small_conflict_cnt", {60'd0, s_conflict_cnt}, 64'(exp_conf));
        end
        abort_in = 1'b1;
        advance(P_NONE, 1'b0);
        checkOutput("result_hold", {61'd0, result}, {61'd0, exp_res});
        checkOutput("conflict_hold", {32'd0, conflict_cnt}, 64'(exp_conf));
    endtask

    task automatic resetMidAnalysis;
        max_conflicts = 32'd0;
        conflict      = 1'b0;
        all_sat       = 1'b0;
        start_core    = 1'b1;
        advance(P_IMP, 1'b1);
        advance(P_NONE, 1'b1);
        done_imply = 1'b1;
        conflict   = 1'b1;
        advance(P_ANA, 1'b1);
        rst = 1'b0;
        advance(P_NONE, 1'b0);
        checkZero("rst_mid");
        rst = 1'b1;
        advance(P_NONE, 1'b0);
        advance(P_NONE, 1'b0);
        checkZero("after_rst");
    endtask

    initial begin
        rst = 1'b0;
        start_core = 1'b0; abort_in = 1'b0; max_conflicts = 32'd0;
        done_imply = 1'b0; conflict = 1'b0; done_decision = 1'b0; all_sat = 1'b0;
        done_analyze = 1'b0; done_bkt = 1'b0; cur_lvl = 16'd0; bkt_bin = 10'd0; cur_bin = 10'd0;
        s_max = 4'd0;
        advance(P_NONE, 1'b0);
        rst = 1'b1;
        advance(P_NONE, 1'b0);
        checkZero("reset");

        abort_in = 1'b1;
        advance(P_NONE, 1'b0);
        checkOutput("idle_abort", {61'd0, result}, {61'd0, RES_NONE});

        applyStimulus(M_SAT, 32'd0, 0, 1'b0);
        applyStimulus(M_UNSAT, 32'd0, 0, 1'b0);
        applyStimulus(M_ABORT, 32'd0, 0, 1'b0);
        applyStimulus(M_CONF, 32'd0, 5, 1'b1);
        applyStimulus(M_CONF, 32'd2, 5, 1'b0);
        for (int n = 0; n < 25; n++) begin
            applyStimulus(M_RANDOM, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 4)) : 32'd0, 0, 1'b0);
        end
        resetMidAnalysis();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/sat_core_ctrl.md
Name: sat_core_ctrl

Overview:
Second-generation sequencer for one SAT engine bin solve. It runs the BCP → decision → conflict-analysis → backtrack loop over a loaded bin and reports SAT, UNSAT (backtrack leaves the bin), BUDGET (conflict limit hit) or ABORT.
Compared with the first-generation controller it adds:
- strict one-cycle start pulses with stale-done protection
- a runtime conflict budget
- an abort input
- encoded result codes
- saturating per-solve statistics counters

It sits between the bin loader/top scheduler and the imply, decision, analyze and backtrack units.

Parameters:
WIDTH_BIN_ID, 10, bin index width
WIDTH_LVL, 16, decision level width
WIDTH_CNT, 32, width of statistics counters and conflict budget

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active low
start_core_i  in  1  start solve; accepted only in IDLE
abort_i  in  1  abort current solve
max_conflicts_i  in  WIDTH_CNT  conflict budget; 0 = unlimited; sampled on accepted start
done_core_o  out  1  one-cycle completion pulse
result_o  out  3  0 NONE, 1 SAT, 2 UNSAT, 3 BUDGET, 4 ABORT
sat_o  out  1  level, result_o==SAT
unsat_o  out  1  level, result_o==UNSAT
busy_o  out  1  FSM not in IDLE
apply_imply_o  out  1  BCP start pulse
done_imply_i  in  1  BCP finished
conflict_i  in  1  BCP found conflict; qualified by done_imply_i
start_decision_o  out  1  decision start pulse
done_decision_i  in  1  decision finished
all_c_is_sat_i  in  1  every clause in bin satisfied
cur_lvl_i  in  WIDTH_LVL  current decision level
apply_analyze_o  out  1  analysis start pulse
done_analyze_i  in  1  analysis finished
bkt_bin_num_i  in  WIDTH_BIN_ID  bin that the backtrack targets
cur_bin_num_i  in  WIDTH_BIN_ID  bin currently loaded
apply_bkt_cur_bin_o  out  1  in-bin backtrack start pulse
done_bkt_cur_bin_i  in  1  backtrack finished
conflict_cnt_o  out  WIDTH_CNT  conflicts this solve
decision_cnt_o  out  WIDTH_CNT  decisions this solve
cycle_cnt_o  out  WIDTH_CNT  busy cycles this solve
max_lvl_o  out  WIDTH_LVL  highest cur_lvl_i seen after a decision

Behaviour:
- Reset (rst==0 at posedge): state IDLE; all outputs 0, including result_o=NONE and all counters. Reset mid-solve aborts silently with no done_core_o pulse.
- States: IDLE, BCP, DECISION, ANALYSIS, BKT_CUR_BIN, REPORT.
- IDLE:
  - start_core_i → BCP next cycle.
  - Same edge: result_o ← NONE, sat_o/unsat_o ← 0, all counters ← 0, budget register ← max_conflicts_i.
  - abort_i is ignored in IDLE.
- Start pulses:
  - apply_imply_o, start_decision_o, apply_analyze_o and apply_bkt_cur_bin_o are registered.
  - Each is high exactly in the first cycle of residency in its state, on every entry, including back-to-back BKT_CUR_BIN→BCP.
  - The matching done input is ignored while its pulse is high. Done inputs are ignored in all other states.
- BCP, on a valid done_imply_i, in priority order:
  - conflict_i: conflict_cnt++. If budget≠0 and the new count ≥ budget → REPORT/BUDGET; else → ANALYSIS.
  - all_c_is_sat_i → REPORT/SAT.
  - otherwise → DECISION.
- DECISION, on a valid done_decision_i:
  - decision_cnt++; max_lvl_o ← max(max_lvl_o, cur_lvl_i).
  - all_c_is_sat_i → REPORT/SAT; else → BCP.
- ANALYSIS, on a valid done_analyze_i:
  - bkt_bin_num_i≠cur_bin_num_i → REPORT/UNSAT.
  - otherwise → BKT_CUR_BIN.
- BKT_CUR_BIN: valid done_bkt_cur_bin_i → BCP.
- abort_i in any state other than IDLE or REPORT:
  - → REPORT/ABORT next cycle.
  - Takes priority over any simultaneous done; that done is discarded and its counter is not updated.
- REPORT:
  - Lasts one cycle, then → IDLE.
  - On entry edge: result_o registered; sat_o/unsat_o follow it.
  - done_core_o is high exactly during the REPORT cycle.
  - result_o and the counters hold until the next accepted start.
  - start_core_i during REPORT is ignored; start must be reissued in IDLE.
- Latency: start edge → apply_imply_o high in the next cycle. Decisive done edge → done_core_o high in the next cycle.
- Counters saturate at all-ones and never wrap. cycle_cnt_o increments every cycle the FSM is not in IDLE, REPORT included.
- busy_o = (state≠IDLE), registered.

Decomposition:
- Package sat_core_pkg: state enum, result code constants (RES_NONE=0, RES_SAT=1, RES_UNSAT=2, RES_BUDGET=3, RES_ABORT=4), result width 3.
- Sub-module sat_sat_cnt: parametrised saturating counter with clr/inc, instantiated three times.
- FSM, pulse generation and max-level tracker stay in sat_core_ctrl.

Test Plan:
- Start; BCP done, no conflict, all_sat=0; decision done at lvl 1; BCP done with all_sat=1 → result SAT, decision_cnt=1, max_lvl=1, one done_core_o pulse, each start pulse exactly 1 cycle.
- Start; BCP conflict; analyze with bkt_bin=3, cur_bin=3; backtrack done; BCP conflict; analyze bkt_bin=2 → result UNSAT, conflict_cnt=2, apply_bkt_cur_bin_o pulsed once.
- max_conflicts_i=2; conflicts on every BCP with in-bin backtracks → BUDGET on the 2nd conflict, only 1 apply_analyze_o pulse. Rerun with max=0 and 5 conflicts → no BUDGET.
- abort_i asserted in the same cycle as done_decision_i → result ABORT, decision_cnt unchanged. abort_i in IDLE → no effect.
- done_imply_i held high from BCP entry (stale done) → ignored during the pulse cycle, accepted from the second cycle. start_core_i during BCP and during REPORT → ignored.
- rst low mid-ANALYSIS → all outputs 0, no done_core_o pulse. cycle_cnt forced near all-ones saturates and does not wrap.
